// File: rtl/ls_down_counter_casc_pkg.sv
// Shared constants and helpers for the cascadable down counter.
// Latency: none (compile-time constants and functions only).
// Backpressure: not applicable.
// Contents: NIBBLE_W slice width, MAX_W upper width bound,
//           nslice() slice-count rule, all_ones() all-ones constant helper.
package ls_down_counter_casc_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned MAX_W    = 64;

  // Number of 4-bit slices needed for a counter of the given width.
  function automatic int unsigned nslice(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

  // All-ones value for a counter of the given width, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] all_ones(input int unsigned width);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ls_down_nibble.sv
// 4-bit synchronous presettable down-counter slice with local borrow out.
// Latency: Q updates one CLK edge after LOAD_n/ENP/ENT are sampled; BO is combinational.
// Backpressure: none; ENP & ENT stall the slice, LOAD_n overrides both.
// Ports: CLK, CLR_n (async active-low), D (preset), LOAD_n, ENP, ENT in;
//        Q (registered count), BO = (Q==0) & ENT out.
module ls_down_nibble
  import ls_down_counter_casc_pkg::*;
(
  input  logic                CLK,
  input  logic                CLR_n,
  input  logic [NIBBLE_W-1:0] D,
  input  logic                LOAD_n,
  input  logic                ENP,
  input  logic                ENT,
  output logic [NIBBLE_W-1:0] Q,
  output logic                BO
);

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      Q <= '0;
    end else if (!LOAD_n) begin
      Q <= D;
    end else if (ENP && ENT) begin
      // Decrementing 0 wraps to F, which is what the next-higher slice
      // expects when it takes the borrow on this same edge.
      Q <= Q - 1'b1;
    end
  end

  // Borrow is qualified by ENT so chaining BO->ENT gives ENT & all-lower-zero.
  assign BO = (Q == '0) && ENT;

endmodule

// File: rtl/ls_down_counter_casc.sv
// Cascadable presettable binary down counter (timer/divider) built from 4-bit slices.
// Latency: Q and TC_PULSE update one CLK edge after the qualifier; RBO is combinational.
// Backpressure: none; ENP & ENT stall counting, RBO follows ENT so external cascades stall too.
// Ports: CLK, CLR_n (async active-low), D (preset), LOAD_n, ENP, ENT in;
//        Q (registered), RBO = (Q==0) & ENT, TC_PULSE (1-cycle pulse after leaving zero) out.
module ls_down_counter_casc
  import ls_down_counter_casc_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             RBO,
  output logic             TC_PULSE
);

  localparam int unsigned      NSLICE   = nslice(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));

  if (WIDTH == 0 || (WIDTH % NIBBLE_W) != 0 || WIDTH > MAX_W) begin : g_bad_width
    $error("ls_down_counter_casc: WIDTH must be a non-zero multiple of 4 and at most 64");
  end

  logic [WIDTH-1:0] preset_reg;
  logic             cnt_en;
  logic             q_zero;
  logic             wrap;
  logic             slice_load_n;
  logic [WIDTH-1:0] slice_d;
  logic [NSLICE:0]  ent_chain;

  assign cnt_en = ENP && ENT;
  assign q_zero = (Q == '0);

  // A count step out of zero is handled by a parallel load of the wrap value
  // (preset or all-ones) rather than by the slices' own decrement, so both
  // AUTO_RELOAD modes share one path and the reload is a single-edge event.
  assign wrap         = LOAD_n && cnt_en && q_zero;
  assign slice_load_n = LOAD_n && !wrap;

  always_comb begin
    slice_d = D;
    if (LOAD_n) begin
      slice_d = AUTO_RELOAD ? preset_reg : ALL_ONES;
    end
  end

  // Internal ripple: slice k sees ENT & borrows of every lower slice.
  assign ent_chain[0] = ENT;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    ls_down_nibble u_nibble (
      .CLK    (CLK),
      .CLR_n  (CLR_n),
      .D      (slice_d[k*NIBBLE_W +: NIBBLE_W]),
      .LOAD_n (slice_load_n),
      .ENP    (ENP),
      .ENT    (ent_chain[k]),
      .Q      (Q[k*NIBBLE_W +: NIBBLE_W]),
      .BO     (ent_chain[k+1])
    );
  end

  // The top slice's borrow is ENT & (whole Q == 0), independent of ENP.
  assign RBO = ent_chain[NSLICE];

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      preset_reg <= '0;
      TC_PULSE   <= 1'b0;
    end else begin
      TC_PULSE <= wrap;
      if (!LOAD_n) begin
        preset_reg <= D;
      end
    end
  end

endmodule

// File: tb/tb_ls_down_counter_casc.sv
// Bench for ls_down_counter_casc: three instances (W4 wrap, W4 auto-reload, W8 wrap)
// share one stimulus stream; a reference model queues expected outputs per cycle,
// and an independent monitor pops and compares one cycle after each edge.
module tb_ls_down_counter_casc;

  logic       CLK    = 1'b0;
  logic       CLR_n  = 1'b0;
  logic [7:0] D8     = 8'h00;
  logic       LOAD_n = 1'b1;
  logic       ENP    = 1'b0;
  logic       ENT    = 1'b0;

  logic [3:0] q_a;
  logic [3:0] q_b;
  logic [7:0] q_c;
  logic       rbo_a, rbo_b, rbo_c;
  logic       tc_a, tc_b, tc_c;

  always #5 CLK = ~CLK;

  ls_down_counter_casc #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_dut_a (
    .CLK(CLK), .CLR_n(CLR_n), .D(D8[3:0]), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
    .Q(q_a), .RBO(rbo_a), .TC_PULSE(tc_a));

  ls_down_counter_casc #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_dut_b (
    .CLK(CLK), .CLR_n(CLR_n), .D(D8[3:0]), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
    .Q(q_b), .RBO(rbo_b), .TC_PULSE(tc_b));

  ls_down_counter_casc #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_dut_c (
    .CLK(CLK), .CLR_n(CLR_n), .D(D8), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
    .Q(q_c), .RBO(rbo_c), .TC_PULSE(tc_c));

  typedef struct packed {
    logic [2:0][7:0] q;
    logic [2:0]      tc;
    logic [2:0]      rbo;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: counter value, latched preset, pulse.
  int m_q [3];
  int m_p [3];
  bit m_tc[3];

  function automatic int wid(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic bit ar(input int i);
    return (i == 1);
  endfunction

  function automatic logic [7:0] act_q(input int i);
    case (i)
      0:       return {4'h0, q_a};
      1:       return {4'h0, q_b};
      default: return q_c;
    endcase
  endfunction

  function automatic logic act_tc(input int i);
    case (i)
      0:       return tc_a;
      1:       return tc_b;
      default: return tc_c;
    endcase
  endfunction

  function automatic logic act_rbo(input int i);
    case (i)
      0:       return rbo_a;
      1:       return rbo_b;
      default: return rbo_c;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i]  = 0;
      m_p[i]  = 0;
      m_tc[i] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs and queue what every instance must show after the edge.
  task automatic step(input logic [7:0] d, input logic ld_n, input logic en_p, input logic en_t);
    exp_t e;
    int   mask;
    @(negedge CLK);
    D8     = d;
    LOAD_n = ld_n;
    ENP    = en_p;
    ENT    = en_t;
    for (int i = 0; i < 3; i++) begin
      mask = (1 << wid(i)) - 1;
      if (!ld_n) begin
        m_q[i]  = int'(d) & mask;
        m_p[i]  = m_q[i];
        m_tc[i] = 1'b0;
      end else if (en_p && en_t) begin
        if (m_q[i] == 0) begin
          m_q[i]  = ar(i) ? m_p[i] : mask;
          m_tc[i] = 1'b1;
        end else begin
          m_q[i]  = m_q[i] - 1;
          m_tc[i] = 1'b0;
        end
      end else begin
        m_tc[i] = 1'b0;
      end
      e.q[i]   = 8'(m_q[i]);
      e.tc[i]  = m_tc[i];
      e.rbo[i] = (m_q[i] == 0) && en_t;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: one cycle's expectations consumed per edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          check($sformatf("q[%0d]", i),   act_q(i),          e.q[i]);
          check($sformatf("tc[%0d]", i),  {7'd0, act_tc(i)}, {7'd0, e.tc[i]});
          check($sformatf("rbo[%0d]", i), {7'd0, act_rbo(i)}, {7'd0, e.rbo[i]});
        end
      end
    end
  end

  initial begin
    model_reset();

    // Reset state with ENT low, then RBO must follow ENT while still in reset.
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_q[%0d]", i),   act_q(i),           8'h00);
      check($sformatf("rst_tc[%0d]", i),  {7'd0, act_tc(i)},  8'h00);
      check($sformatf("rst_rbo0[%0d]", i), {7'd0, act_rbo(i)}, 8'h00);
    end
    ENT = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_rbo1[%0d]", i), {7'd0, act_rbo(i)}, 8'h01);
    @(negedge CLK);
    CLR_n = 1'b1;

    // Load 9 and hold, then reset in the middle of a cycle.
    step(8'h09, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    @(posedge CLK);
    #3;
    LOAD_n = 1'b1;
    ENP    = 1'b0;
    ENT    = 1'b1;
    CLR_n  = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midrst_q[%0d]", i),   act_q(i),           8'h00);
      check($sformatf("midrst_tc[%0d]", i),  {7'd0, act_tc(i)},  8'h00);
      check($sformatf("midrst_rbo[%0d]", i), {7'd0, act_rbo(i)}, 8'h01);
    end
    model_reset();
    @(negedge CLK);
    CLR_n = 1'b1;

    // Preset was cleared by reset: auto-reload instance must stay at 0.
    repeat (3) step(8'h00, 1'b1, 1'b1, 1'b1);

    // Load 3 and count through zero.
    step(8'h03, 1'b0, 1'b0, 1'b0);
    repeat (6) step(8'h00, 1'b1, 1'b1, 1'b1);

    // Load 2 and count: reload period of 3 on the auto-reload instance.
    step(8'h02, 1'b0, 1'b0, 1'b0);
    repeat (7) step(8'h00, 1'b1, 1'b1, 1'b1);

    // Enable gating at zero: ENP low holds, then ENT low kills RBO.
    step(8'h01, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b0);

    // Load beats count at zero; no pulse.
    step(8'h01, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b1, 1'b1);
    step(8'h05, 1'b0, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b1);

    // Zero preset with auto-reload: pulse every enabled cycle.
    step(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) step(8'h00, 1'b1, 1'b1, 1'b1);

    // Cascade across the nibble boundary: 0x10 down to 0xFF in 17 edges.
    step(8'h10, 1'b0, 1'b0, 1'b0);
    repeat (17) step(8'h00, 1'b1, 1'b1, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(8'($urandom),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
      @(posedge CLK);
      #2;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
